// File: rtl/mem_to_host_packer.sv
// mem_to_host_packer: reads consecutive local memory words and packs them into cache lines for the host DMA write FIFO
module mem_to_host_packer #(
    parameter int CL_ADDR_WIDTH = 42,
    parameter int SIZE_WIDTH    = CL_ADDR_WIDTH + 1,
    parameter int WORD_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 16,
    parameter int CL_WIDTH      = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [SIZE_WIDTH-1:0] size_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    output logic                  mem_en_o,
    output logic                  mem_wr_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [WORD_WIDTH-1:0] mem_out_i,
    input  logic                  mem_valid_i,
    input  logic                  full_i,
    output logic [CL_WIDTH-1:0]   wr_data_o,
    output logic                  wr_en_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int WORDS_PER_CL = CL_WIDTH / WORD_WIDTH;
    localparam int K_W = (WORDS_PER_CL > 1) ? $clog2(WORDS_PER_CL) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(WORDS_PER_CL - 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, PUSH, FIN} state_t;

    state_t                state_q, state_d;
    logic [SIZE_WIDTH-1:0] size_q, size_d;
    logic [SIZE_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [K_W-1:0]        k_q, k_d;
    logic [CL_WIDTH-1:0]   line_q, line_d;
    logic [SIZE_WIDTH-1:0] cnt_inc;

    assign cnt_inc     = cnt_q + 1'b1;
    assign mem_en_o    = (state_q == REQ);
    assign mem_wr_en_o = 1'b0;
    assign mem_addr_o  = addr_q;
    assign wr_data_o   = line_q;
    assign wr_en_o     = (state_q == PUSH) && !full_i;
    assign busy_o      = (state_q == REQ) || (state_q == WAIT) || (state_q == PUSH);
    assign done_o      = (state_q == FIN);

    // State and datapath registers; reset drops any partial line and clears the outputs at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            size_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            k_q     <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            k_q     <= k_d;
            line_q  <= line_d;
        end
    end

    // Next-state logic: one read in flight, capture into lane k, push the full line when the FIFO has room
    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        k_d     = k_q;
        line_d  = line_q;
        case (state_q)
            IDLE, FIN: begin
                if (start_i) begin
                    if (size_i == '0) begin
                        state_d = FIN;
                    end else begin
                        size_d  = size_i;
                        addr_d  = base_addr_i;
                        k_d     = '0;
                        cnt_d   = '0;
                        state_d = REQ;
                    end
                end
            end
            REQ: state_d = WAIT;
            WAIT: begin
                if (mem_valid_i) begin
                    line_d[WORD_WIDTH*k_q +: WORD_WIDTH] = mem_out_i;
                    addr_d  = addr_q + 1'b1;
                    k_d     = (k_q == K_LAST) ? '0 : k_q + 1'b1;
                    state_d = (k_q == K_LAST) ? PUSH : REQ;
                end
            end
            PUSH: begin
                if (!full_i) begin
                    cnt_d   = cnt_inc;
                    k_d     = '0;
                    state_d = (cnt_inc == size_q) ? FIN : REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_to_host_packer.sv
// tb_mem_to_host_packer: directed and randomized checks of the packer against a memory/FIFO reference model
module tb_mem_to_host_packer;
    localparam int SW = 43;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [SW-1:0] size_i = '0;
    logic [15:0]   base_addr_i = '0;
    logic          mem_en_o, mem_wr_en_o;
    logic [15:0]   mem_addr_o;
    logic [31:0]   mem_out_i = '0;
    logic          mem_valid_i = 1'b0;
    logic          full_i = 1'b0;
    logic [511:0]  wr_data_o;
    logic          wr_en_o, busy_o, done_o;

    mem_to_host_packer dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .size_i(size_i), .base_addr_i(base_addr_i),
        .mem_en_o(mem_en_o), .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o),
        .mem_out_i(mem_out_i), .mem_valid_i(mem_valid_i), .full_i(full_i),
        .wr_data_o(wr_data_o), .wr_en_o(wr_en_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    logic [31:0]  mem [65536];
    logic [15:0]  req_q [$];
    logic [511:0] push_q [$];
    logic [15:0]  paddr = '0;
    int  lat = 1, pend = 0, vcnt = 0;
    bit  spur = 0, rand_full = 0, full_force = 0;
    int  total = 0, fails = 0;

    // Memory model: answers each request lat cycles later, optionally injects a stray valid during the request cycle
    always @(negedge clk) begin
        mem_valid_i = 1'b0;
        mem_out_i   = $urandom;
        full_i      = rand_full ? ($urandom_range(0, 2) == 0) : full_force;
        if (!rst_n) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_valid_i = 1'b1;
                    mem_out_i   = mem[paddr];
                    vcnt++;
                end
            end
            if (mem_en_o) begin
                req_q.push_back(mem_addr_o);
                paddr = mem_addr_o;
                pend  = lat;
                if (spur) mem_valid_i = 1'b1;
            end
        end
    end

    // FIFO model: records every pushed line once full_i has settled for the cycle
    always @(negedge clk) begin
        #2;
        if (rst_n && wr_en_o) push_q.push_back(wr_data_o);
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    task automatic start_xfer(input logic [15:0] b, input logic [SW-1:0] s);
        req_q.delete();
        push_q.delete();
        base_addr_i = b;
        size_i      = s;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done_o && n < 5000) begin
            tick();
            n++;
        end
        chk({tag, " done_reached"}, done_o, 1);
    endtask

    task automatic check_xfer(input string tag, input logic [15:0] b, input int s);
        logic [511:0] e;
        chk({tag, " req_count"}, req_q.size(), 16 * s);
        for (int i = 0; i < req_q.size() && i < 16 * s; i++)
            chk($sformatf("%s addr%0d", tag, i), req_q[i], 16'(b + i));
        chk({tag, " push_count"}, push_q.size(), s);
        for (int j = 0; j < push_q.size() && j < s; j++) begin
            for (int i = 0; i < 16; i++) e[32*i +: 32] = mem[16'(b + 16 * j + i)];
            chk($sformatf("%s line%0d", tag, j), push_q[j], e);
        end
        chk({tag, " busy_after"}, busy_o, 0);
        chk({tag, " wr_en_after"}, wr_en_o, 0);
    endtask

    initial begin
        logic [511:0] snap;
        int v0, n;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        repeat (3) tick();
        chk("rst mem_en", mem_en_o, 0);
        chk("rst mem_addr", mem_addr_o, 0);
        chk("rst wr_en", wr_en_o, 0);
        chk("rst wr_data", wr_data_o, 0);
        chk("rst busy", busy_o, 0);
        chk("rst done", done_o, 0);
        chk("rst mem_wr_en", mem_wr_en_o, 0);
        rst_n = 1'b1;
        tick();

        start_xfer(16'h1234, '0);
        if (!done_o) tick();
        chk("size0 done", done_o, 1);
        repeat (5) tick();
        chk("size0 req_count", req_q.size(), 0);
        chk("size0 push_count", push_q.size(), 0);
        chk("size0 busy", busy_o, 0);

        for (int i = 0; i < 16; i++) mem[16 + i] = 32'(i + 1);
        lat = 1;
        start_xfer(16'h0010, 1);
        wait_done("basic");
        check_xfer("basic", 16'h0010, 1);
        chk("basic word0", push_q.size() > 0 ? push_q[0][31:0] : 32'hx, 1);
        chk("basic word15", push_q.size() > 0 ? push_q[0][511:480] : 32'hx, 16);
        chk("basic mem_wr_en", mem_wr_en_o, 0);

        lat = 2;
        start_xfer(16'hFFF8, 2);
        wait_done("wrap");
        check_xfer("wrap", 16'hFFF8, 2);
        chk("wrap l1w0", push_q.size() > 1 ? push_q[1][31:0] : 32'hx, mem[16'h0008]);

        lat = 1;
        full_force = 1;
        start_xfer(16'h0200, 1);
        n = 0;
        while (req_q.size() < 16 && n < 500) begin
            tick();
            n++;
        end
        chk("full reqs_issued", req_q.size(), 16);
        repeat (lat + 1) tick();
        snap = wr_data_o;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("full wr_en c%0d", k), wr_en_o, 0);
            chk($sformatf("full hold c%0d", k), wr_data_o, snap);
            chk($sformatf("full mem_en c%0d", k), mem_en_o, 0);
            chk($sformatf("full busy c%0d", k), busy_o, 1);
            if (k == 4) full_force = 0;
            tick();
        end
        wait_done("full");
        check_xfer("full", 16'h0200, 1);

        lat = 1;
        v0 = vcnt;
        start_xfer(16'h0300, 1);
        n = 0;
        while (vcnt < v0 + 7 && n < 500) begin
            tick();
            n++;
        end
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst mem_en", mem_en_o, 0);
        chk("midrst mem_addr", mem_addr_o, 0);
        chk("midrst wr_en", wr_en_o, 0);
        chk("midrst wr_data", wr_data_o, 0);
        chk("midrst busy", busy_o, 0);
        chk("midrst done", done_o, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        req_q.delete();
        push_q.delete();
        repeat (30) tick();
        chk("postrst req_count", req_q.size(), 0);
        chk("postrst push_count", push_q.size(), 0);
        start_xfer(16'h0400, 1);
        wait_done("restart");
        check_xfer("restart", 16'h0400, 1);

        spur = 1;
        start_xfer(16'h0010, 1);
        repeat (7) tick();
        base_addr_i = 16'h0500;
        size_i      = 3;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
        wait_done("ignore");
        spur = 0;
        check_xfer("ignore", 16'h0010, 1);

        rand_full = 1;
        for (int r = 0; r < 6; r++) begin
            logic [15:0] b;
            int s;
            b    = 16'($urandom);
            s    = $urandom_range(1, 3);
            lat  = $urandom_range(1, 4);
            spur = ($urandom_range(0, 1) == 1);
            start_xfer(b, SW'(s));
            wait_done($sformatf("rnd%0d", r));
            check_xfer($sformatf("rnd%0d", r), b, s);
        end
        rand_full = 0;
        spur = 0;

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/mem_to_host_packer.md
MEM_TO_HOST_PACKER -- requirements
Module: mem_to_host_packer

Interface
REQ-001 Parameter CL_ADDR_WIDTH, default 42, host cache-line address width.
REQ-002 Parameter SIZE_WIDTH, default CL_ADDR_WIDTH+1, width of the cache-line count.
REQ-003 Parameter WORD_WIDTH, default 32, local memory data width.
REQ-004 Parameter ADDR_WIDTH, default 16, local memory word-address width.
REQ-005 Parameter CL_WIDTH, default 512, cache-line width; WORDS_PER_CL = CL_WIDTH/WORD_WIDTH (16).
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous and active-low.
REQ-008 start  in  1  one-cycle request to begin write-back (from CPU halt).
REQ-009 size  in  SIZE_WIDTH  number of cache lines to send, sampled on accepted start.
REQ-010 base_addr  in  ADDR_WIDTH  first local word address, sampled on accepted start.
REQ-011 mem_en  out  1  local memory read request.
REQ-012 mem_wr_en  out  1  memory write enable, constant 0.
REQ-013 mem_addr  out  ADDR_WIDTH  word address of the current request.
REQ-014 mem_out  in  WORD_WIDTH  read data from memory controller.
REQ-015 mem_valid  in  1  mem_out valid this cycle.
REQ-016 full  in  1  DMA write FIFO full.
REQ-017 wr_data  out  CL_WIDTH  packed cache line to DMA.
REQ-018 wr_en  out  1  push wr_data into DMA write FIFO.
REQ-019 busy  out  1  transfer in progress.
REQ-020 done  out  1  transfer complete, level.

Function
REQ-021 States: IDLE, REQ, WAIT, PUSH, FIN; busy SHALL be 1 in REQ/WAIT/PUSH only.
REQ-022 start SHALL be accepted only in IDLE or FIN; ignored otherwise.
REQ-023 On accepted start with size != 0: latch size, base_addr; clear word index, line count, done; go to REQ.
REQ-024 On accepted start with size == 0: go to FIN next cycle with no memory request and no wr_en.
REQ-025 REQ: mem_en=1 for exactly one cycle with mem_addr = current address; next state WAIT.
REQ-026 WAIT: mem_en=0, mem_addr held; on mem_valid, write mem_out into line buffer lane [WORD_WIDTH*k +: WORD_WIDTH], k = word index (word 0 in LSBs).
REQ-027 After capture: address +1 modulo 2^ADDR_WIDTH (0xFFFF wraps to 0x0000); if k < 15, k+1 and go to REQ, else go to PUSH.
REQ-028 Exactly one outstanding read; mem_valid outside WAIT SHALL be ignored.
REQ-029 PUSH: wr_en = !full; wr_data stable from PUSH entry until the push cycle.
REQ-030 While full=1, stay in PUSH with wr_en=0, no memory requests.
REQ-031 On push (wr_en=1): line count +1, k=0; if line count equals size go to FIN, else REQ.
REQ-032 Minimum latency per line: 16 x (1 + memory latency) cycles plus one push cycle.
REQ-033 FIN: done=1, held until next accepted start; wr_en=0, mem_en=0.
REQ-034 Line count and size comparisons SHALL use full SIZE_WIDTH, no truncation.
REQ-035 mem_wr_en SHALL be 0 in all states.

Reset
REQ-036 rst_n low SHALL immediately force IDLE, mem_en=0, mem_addr=0, wr_en=0, wr_data=0, busy=0, done=0, counters 0.
REQ-037 Reset mid-transfer SHALL abandon the partial line; no wr_en after release until a new start.
REQ-038 After rst_n release, first accepted start no earlier than the first clock edge.

Verification
REQ-039 base_addr=0x0010, size=1, memory[0x10+i]=i+1, latency 1, full=0 -> 16 reads 0x10..0x1F, one wr_en, wr_data word i = i+1, done=1.
REQ-040 size=2, base_addr=0xFFF8 -> reads 0xFFF8..0xFFFF, 0x0000..0x0017, two wr_en pulses, line 1 word 0 = memory[0x0008].
REQ-041 full=1 held 5 cycles at PUSH entry -> wr_en=0 for 5 cycles, wr_data unchanged, single push after full drops.
REQ-042 size=0 start -> done=1 within 2 cycles, zero mem_en, zero wr_en.
REQ-043 rst_n low after 7th word of size=1 transfer -> all outputs 0 at once; no wr_en before next start; new start rereads from new base_addr.
REQ-044 start pulsed while busy, and spurious mem_valid in REQ -> ignored; data and line count match REQ-039 result.
